frame_gen_padded_stream: RTL

- Parametrised successor to the fixed 16-byte frame generator.
- Captures a variable-length payload of up to MAX_PAYLOAD words on `start`.
- Emits SOF, the payload, pad words up to MIN_FRAME total beats, then EOF, on a valid/ready output stream with backpressure.
- Sits between the packet assembly logic and the line serialiser.

---
 rtl/frame_gen_pkg.sv | 22 ++
 rtl/frame_fcs_acc.sv | 31 +++
 rtl/frame_gen_padded_stream.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/frame_gen_pkg.sv
// frame_gen_pkg: shared state type, default marker codes and sizing helper
// for the padded frame generator.
package frame_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_EOF
  } frame_state_t;

  localparam logic [7:0] DEF_SOF_CODE = 8'h7E;
  localparam logic [7:0] DEF_EOF_CODE = 8'h7F;
  localparam logic [7:0] DEF_PAD_CODE = 8'h00;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_fcs_acc.sv
// frame_fcs_acc: running XOR of the data words of one frame, cleared when a
// new frame is accepted and advanced once per transferred payload/pad beat.
module frame_fcs_acc
  import frame_gen_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_acc
);

  logic [DATA_W-1:0] r_acc;

  // Fold each enabled word into the checksum; a clear starts a fresh frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/frame_gen_padded_stream.sv
// frame_gen_padded_stream: captures a variable-length payload on start and
// streams SOF, payload, pad words up to MIN_FRAME beats, then EOF, on a
// valid/ready interface with backpressure.
// Optional FCS beat before EOF is built when FRAME_GEN_FCS_EN is defined.
module frame_gen_padded_stream
  import frame_gen_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                MAX_PAYLOAD = 16,
  parameter int                MIN_FRAME   = 64,
  parameter logic [DATA_W-1:0] SOF_CODE    = DATA_W'(DEF_SOF_CODE),
  parameter logic [DATA_W-1:0] EOF_CODE    = DATA_W'(DEF_EOF_CODE),
  parameter logic [DATA_W-1:0] PAD_CODE    = DATA_W'(DEF_PAD_CODE)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 start_ready,
  input  logic [MAX_PAYLOAD*DATA_W-1:0]        payload_in,
  input  logic [$clog2(MAX_PAYLOAD+1)-1:0]     payload_len,
  output logic [DATA_W-1:0]                    out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_sof,
  output logic                                 out_eof,
  output logic                                 len_err,
  output logic                                 done
);

`ifdef FRAME_GEN_FCS_EN
  localparam int OVH = 3;
`else
  localparam int OVH = 2;
`endif
  localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);
  localparam int CNT_W = $clog2(max_int(MIN_FRAME, MAX_PAYLOAD + 3) + 1);

  if (MIN_FRAME < OVH) begin : g_badMinFrame
    $error("frame_gen_padded_stream: MIN_FRAME smaller than frame overhead");
  end
  if (MAX_PAYLOAD < 1) begin : g_badMaxPayload
    $error("frame_gen_padded_stream: MAX_PAYLOAD must be at least 1");
  end

  frame_state_t                  r_state;
  logic [MAX_PAYLOAD*DATA_W-1:0] r_buf;
  logic [LEN_W-1:0]              r_effLen;
  logic [LEN_W-1:0]              r_idx;
  logic [CNT_W-1:0]              r_cnt;
  logic [DATA_W-1:0]             r_outData;
  logic                          r_outValid;
  logic                          r_outSof;
  logic                          r_outEof;
  logic                          r_startReady;
  logic                          r_lenErr;
  logic                          r_done;

  logic                          w_accept;
  logic                          w_handshake;
  logic                          w_tooLong;
  logic                          w_morePayload;
  logic [CNT_W-1:0]              w_cntNext;
  logic [CNT_W-1:0]              w_lenPlusOvh;
  logic [CNT_W-1:0]              w_target;
  logic [CNT_W-1:0]              w_padLimit;

  assign w_accept      = (r_state == ST_IDLE) && start;
  assign w_handshake   = r_outValid && out_ready;
  assign w_tooLong     = payload_len > LEN_W'(MAX_PAYLOAD);
  assign w_morePayload = r_idx < r_effLen;
  assign w_cntNext     = r_cnt + CNT_W'(1);
  // Frame length is the larger of the natural length and the minimum frame;
  // padding stops once only the trailer beats (FCS/EOF) remain.
  assign w_lenPlusOvh  = CNT_W'(r_effLen) + CNT_W'(OVH);
  assign w_target      = (w_lenPlusOvh > CNT_W'(MIN_FRAME)) ? w_lenPlusOvh : CNT_W'(MIN_FRAME);
  assign w_padLimit    = w_target - CNT_W'(OVH - 1);

`ifdef FRAME_GEN_FCS_EN
  logic              w_dataBeat;
  logic              w_fcsEnable;
  logic [DATA_W-1:0] w_fcsAcc;
  logic [DATA_W-1:0] w_fcsNext;

  assign w_dataBeat  = (r_state == ST_PAYLOAD) || (r_state == ST_PAD);
  assign w_fcsEnable = w_handshake && w_dataBeat;
  // The beat leaving now is not yet in the accumulator, so fold it in here.
  assign w_fcsNext   = w_fcsAcc ^ (w_dataBeat ? r_outData : '0);

  frame_fcs_acc #(
    .DATA_W (DATA_W)
  ) u_fcsAcc (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_accept),
    .i_enable (w_fcsEnable),
    .i_data   (r_outData),
    .o_acc    (w_fcsAcc)
  );
`endif

  // Frame sequencer: latches the request in IDLE, then advances one beat per
  // handshake with all stream outputs registered so they hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_buf        <= '0;
      r_effLen     <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_outData    <= '0;
      r_outValid   <= 1'b0;
      r_outSof     <= 1'b0;
      r_outEof     <= 1'b0;
      r_startReady <= 1'b1;
      r_lenErr     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          r_buf        <= payload_in;
          r_effLen     <= w_tooLong ? LEN_W'(MAX_PAYLOAD) : payload_len;
          r_lenErr     <= w_tooLong;
          r_idx        <= '0;
          r_cnt        <= '0;
          r_state      <= ST_SOF;
          r_outData    <= SOF_CODE;
          r_outValid   <= 1'b1;
          r_outSof     <= 1'b1;
          r_startReady <= 1'b0;
        end
      end else if (w_handshake) begin
        r_cnt    <= w_cntNext;
        r_outSof <= 1'b0;
        if (r_state == ST_EOF) begin
          r_state      <= ST_IDLE;
          r_outData    <= '0;
          r_outValid   <= 1'b0;
          r_outEof     <= 1'b0;
          r_startReady <= 1'b1;
          r_done       <= 1'b1;
        end
`ifdef FRAME_GEN_FCS_EN
        else if (r_state == ST_FCS) begin
          r_state   <= ST_EOF;
          r_outData <= EOF_CODE;
          r_outEof  <= 1'b1;
        end
`endif
        else if (w_morePayload) begin
          r_state   <= ST_PAYLOAD;
          r_outData <= r_buf[DATA_W-1:0];
          r_buf     <= r_buf >> DATA_W;
          r_idx     <= r_idx + LEN_W'(1);
        end else if (w_cntNext < w_padLimit) begin
          r_state   <= ST_PAD;
          r_outData <= PAD_CODE;
        end else begin
`ifdef FRAME_GEN_FCS_EN
          r_state   <= ST_FCS;
          r_outData <= w_fcsNext;
`else
          r_state   <= ST_EOF;
          r_outData <= EOF_CODE;
          r_outEof  <= 1'b1;
`endif
        end
      end
    end
  end

  assign start_ready = r_startReady;
  assign out_data    = r_outData;
  assign out_valid   = r_outValid;
  assign out_sof     = r_outSof;
  assign out_eof     = r_outEof;
  assign len_err     = r_lenErr;
  assign done        = r_done;

endmodule
